// File: rtl/fp_add_arbiter.sv
// Two-requester arbiter/sequencer in front of a shared sign-magnitude mantissa adder.
// Define FP_ADD_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module fp_add_arbiter #(
  parameter int W       = 53,
  parameter int TIMEOUT = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         r0_valid,
  output logic         r0_ready,
  input  logic         r0_op,
  input  logic [W-1:0] r0_a,
  input  logic [W-1:0] r0_b,
  input  logic         r0_sa,
  input  logic         r0_sb,
  input  logic         r1_valid,
  output logic         r1_ready,
  input  logic         r1_op,
  input  logic [W-1:0] r1_a,
  input  logic [W-1:0] r1_b,
  input  logic         r1_sa,
  input  logic         r1_sb,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_cout,
  output logic         rsp_sign,
  output logic         rsp_err,
  output logic         add_en,
  output logic         add_load,
  output logic         add_op,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  output logic         add_sa,
  output logic         add_sb,
  output logic         add_cin,
  input  logic [W-1:0] add_sum,
  input  logic         add_cout,
  input  logic         add_sign,
  input  logic         add_ready
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_RESP} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t       state, state_nxt;
  logic [7:0]   wait_cnt;
  logic         gnt0, gnt1, accept, is_idle;
  logic         hold_op, hold_sa, hold_sb;
  logic [W-1:0] hold_a, hold_b;

  assign is_idle = (state == S_IDLE);
  assign accept  = gnt0 | gnt1;

`ifdef FP_ADD_ARB_RR_EN
  // rr_ptr names the requester that wins the next tie
  logic rr_ptr;

  always_ff @(posedge clk) begin
    if (rst)         rr_ptr <= 1'b0;
    else if (accept) rr_ptr <= gnt0;
  end

  assign gnt0 = is_idle & r0_valid & (~r1_valid | ~rr_ptr);
  assign gnt1 = is_idle & r1_valid & (~r0_valid |  rr_ptr);
`else
  assign gnt0 = is_idle & r0_valid;
  assign gnt1 = is_idle & r1_valid & ~r0_valid;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_LOAD;
      S_LOAD: state_nxt = S_WAIT;
      S_WAIT: if (add_ready || wait_cnt == TO_LAST) state_nxt = S_RESP;
      S_RESP: if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    add_en    = (state == S_LOAD) || (state == S_WAIT);
    add_load  = (state == S_LOAD);
    rsp_valid = (state == S_RESP);
    r0_ready  = gnt0;
    r1_ready  = gnt1;
    add_cin   = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst || state == S_LOAD) wait_cnt <= '0;
    else if (state == S_WAIT)   wait_cnt <= wait_cnt + 8'd1;
  end

  // Operands stay frozen from accept until the next accept, so the adder sees them live through WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_op <= 1'b0;
      hold_a  <= '0;
      hold_b  <= '0;
      hold_sa <= 1'b0;
      hold_sb <= 1'b0;
      rsp_id  <= 1'b0;
    end else if (accept) begin
      hold_op <= gnt1 ? r1_op : r0_op;
      hold_a  <= gnt1 ? r1_a  : r0_a;
      hold_b  <= gnt1 ? r1_b  : r0_b;
      hold_sa <= gnt1 ? r1_sa : r0_sa;
      hold_sb <= gnt1 ? r1_sb : r0_sb;
      rsp_id  <= gnt1;
    end
  end

  assign add_op = hold_op;
  assign add_a  = hold_a;
  assign add_b  = hold_b;
  assign add_sa = hold_sa;
  assign add_sb = hold_sb;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_sign <= 1'b0;
      rsp_err  <= 1'b0;
    end else if (state == S_WAIT) begin
      if (add_ready) begin
        rsp_sum  <= add_sum;
        rsp_cout <= add_cout;
        rsp_sign <= add_sign;
        rsp_err  <= 1'b0;
      end else if (wait_cnt == TO_LAST) begin
        rsp_sum  <= '0;
        rsp_cout <= 1'b0;
        rsp_sign <= 1'b0;
        rsp_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Scoreboard bench for fp_add_arbiter with a behavioural stub mantissa adder.
module tb_fp_add_arbiter;
  localparam int W       = 53;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic r0_valid = 0, r0_op = 0, r0_sa = 0, r0_sb = 0;
  logic r1_valid = 0, r1_op = 0, r1_sa = 0, r1_sb = 0;
  logic [W-1:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
  logic r0_ready, r1_ready;
  logic rsp_valid, rsp_id, rsp_cout, rsp_sign, rsp_err;
  logic rsp_ready = 1'b1;
  logic [W-1:0] rsp_sum;
  logic add_en, add_load, add_op, add_sa, add_sb, add_cin;
  logic [W-1:0] add_a, add_b;
  logic [W-1:0] add_sum = '0;
  logic add_cout = 0, add_sign = 0, add_ready = 0;

  fp_add_arbiter #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
    .r0_sa(r0_sa), .r0_sb(r0_sb),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
    .r1_sa(r1_sa), .r1_sb(r1_sb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .rsp_sign(rsp_sign), .rsp_err(rsp_err),
    .add_en(add_en), .add_load(add_load), .add_op(add_op), .add_a(add_a), .add_b(add_b),
    .add_sa(add_sa), .add_sb(add_sb), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .add_sign(add_sign), .add_ready(add_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub adder: load clears ready, computes on the next enabled edge unless stuck
  logic stuck = 1'b0;
  logic pend = 1'b0;
  logic [W:0] stub_res;
  logic stub_sign, stub_sub;
  always_comb begin
    stub_sub  = add_op ^ add_sa ^ add_sb;
    stub_res  = stub_sub ? ({1'b0, add_a} + {1'b0, ~add_b} + {{W{1'b0}}, 1'b1})
                         : ({1'b0, add_a} + {1'b0, add_b});
    stub_sign = stub_sub ? (add_sa ^ (add_a < add_b)) : add_sa;
  end
  always @(posedge clk) begin
    if (add_en && add_load) begin
      pend      <= 1'b1;
      add_ready <= 1'b0;
    end else if (add_en && pend && !stuck) begin
      pend      <= 1'b0;
      add_ready <= 1'b1;
      add_sum   <= stub_res[W-1:0];
      add_cout  <= stub_res[W];
      add_sign  <= stub_sign;
    end
  end

  typedef struct {
    logic         id;
    logic [W-1:0] sum;
    logic         cout, sign, err;
    int           t0, lat;
  } exp_t;
  exp_t sb_q[$];

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: response scoreboard plus operand-hold check during WAIT
  logic prev_v = 1'b0;
  int rise_cyc = 0;
  logic [2*W+2:0] add_snap = '0;
  always @(negedge clk) begin
    if (rsp_valid && !prev_v) rise_cyc = cyc;
    prev_v = rsp_valid;
    if (rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rsp", 64'(rsp_valid), 64'(0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rsp_fields", 64'({rsp_id, rsp_cout, rsp_sign, rsp_err, rsp_sum}),
              64'({e.id, e.cout, e.sign, e.err, e.sum}));
        check("rsp_latency", 64'(rise_cyc - e.t0), 64'(e.lat));
      end
    end
    if (add_en && add_load) add_snap = {add_op, add_sa, add_sb, add_a, add_b};
    else if (add_en)
      check("add_hold", 64'({add_cin, add_op, add_sa, add_sb, add_a ^ add_b}),
            64'({1'b0, add_snap[2*W+2:2*W], add_snap[2*W-1:W] ^ add_snap[W-1:0]}));
  end

  task automatic issue(input logic id, input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sa, input logic sb, input bit push, input logic [W-1:0] es,
                       input logic ec, input logic eg, input logic ee, input int lat);
    bit got;
    exp_t e;
    @(posedge clk) #1;
    if (id) begin r1_valid = 1; r1_op = op; r1_a = a; r1_b = b; r1_sa = sa; r1_sb = sb; end
    else    begin r0_valid = 1; r0_op = op; r0_a = a; r0_b = b; r0_sa = sa; r0_sb = sb; end
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (id ? r1_ready : r0_ready) got = 1;
    end
    check("accept", 64'(got), 64'(1));
    if (got && push) begin
      e.id = id; e.sum = es; e.cout = ec; e.sign = eg; e.err = ee; e.t0 = cyc + 1; e.lat = lat;
      sb_q.push_back(e);
    end
    @(posedge clk) #1;
    if (id) r1_valid = 0; else r0_valid = 0;
    @(negedge clk);
    check("ready_pulse", 64'({r0_ready, r1_ready}), 64'(0));
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge clk);
    check("drain", 64'(sb_q.size()), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    check({name, "_ctrl"}, 64'({rsp_valid, rsp_id, rsp_cout, rsp_sign, rsp_err, add_en, add_load,
                                add_op, add_sa, add_sb, add_cin, r0_ready, r1_ready}), 64'(0));
    check({name, "_sum"}, 64'(rsp_sum), 64'(0));
    check({name, "_ops"}, 64'(add_a | add_b), 64'(0));
  endtask

  localparam logic [W-1:0] ALL1 = {W{1'b1}};
  localparam logic [W-1:0] M2   = {{(W-1){1'b1}}, 1'b0};

  initial begin
    logic grants [4];
    logic exp_g [4];
    int ng;
    logic [W+3:0] snap;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk) #1 rst = 0;

    issue(0, 0, 53'd5, 53'd3, 0, 0, 1, 53'd8, 0, 0, 0, 3);
    drain();
    issue(1, 1, 53'd3, 53'd5, 0, 0, 1, M2, 0, 1, 0, 3);
    drain();
    issue(0, 0, ALL1, 53'd1, 0, 0, 1, 53'd0, 1, 0, 0, 3);
    drain();
    issue(1, 0, 53'd10, 53'd4, 1, 0, 1, 53'd6, 1, 1, 0, 3);
    drain();

    // Contention: both requesters valid continuously
    @(posedge clk) #1;
    r0_valid = 1; r0_op = 0; r0_a = 53'd1; r0_b = 53'd2; r0_sa = 0; r0_sb = 0;
    r1_valid = 1; r1_op = 1; r1_a = 53'd9; r1_b = 53'd4; r1_sa = 0; r1_sb = 0;
    ng = 0;
    for (int i = 0; i < 80 && ng < 4; i++) begin
      @(negedge clk);
      if (r0_ready || r1_ready) begin
        exp_t e;
        check("ready_onehot", 64'(r0_ready & r1_ready), 64'(0));
        grants[ng] = r1_ready;
        e.id = r1_ready; e.sum = r1_ready ? 53'd5 : 53'd3; e.cout = r1_ready; e.sign = 0;
        e.err = 0; e.t0 = cyc + 1; e.lat = 3;
        sb_q.push_back(e);
        ng++;
      end
    end
    check("contention_grants", 64'(ng), 64'(4));
    @(posedge clk) #1;
    r0_valid = 0; r1_valid = 0;
`ifdef FP_ADD_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 4; i++) check("grant_order", 64'(grants[i]), 64'(exp_g[i]));
    drain();

    // Back-pressure with a competing request pending
    @(posedge clk) #1 rsp_ready = 0;
    issue(0, 0, 53'd7, 53'd7, 0, 0, 1, 53'd14, 0, 0, 0, 3);
    @(posedge clk) #1;
    r1_valid = 1; r1_op = 0; r1_a = 53'd1; r1_b = 53'd1;
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    snap = {rsp_valid, rsp_id, rsp_cout, rsp_sign, rsp_err, rsp_sum} >> 1;
    check("bp_valid", 64'(rsp_valid), 64'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", 64'({rsp_valid, rsp_id, rsp_cout, rsp_sign, rsp_err, rsp_sum} >> 1), 64'(snap));
      check("bp_quiet", 64'({r0_ready, r1_ready, add_en, add_load}), 64'(0));
    end
    @(posedge clk) #1;
    r1_valid = 0; rsp_ready = 1;
    drain();

    // Timeout: adder never reports ready
    @(posedge clk) #1 stuck = 1;
    issue(1, 0, 53'd1, 53'd1, 0, 0, 1, 53'd0, 0, 0, 1, 1 + TIMEOUT);
    drain();
    @(posedge clk) #1 stuck = 0;

    // Reset in the middle of WAIT discards the operation
    issue(0, 0, 53'd100, 53'd200, 1, 1, 0, 53'd0, 0, 0, 0, 0);
    @(posedge clk) #1 rst = 1;
    @(posedge clk) #1 rst = 0;
    @(negedge clk);
    check_zero("mid_wait_reset");
    repeat (12) @(negedge clk);
    issue(0, 0, 53'd20, 53'd22, 0, 0, 1, 53'd42, 0, 0, 0, 3);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
